phase_enable_gen: RTL and testbench
===================================

// Module: phase_enable_gen
// PURPOSE
//  Sits directly downstream of the clock generator. Runs on its buffered fast clock and
//  derives one-clkin-wide enable strobes for the 1.79 MHz machine-cycle phases (phi1/phi2).
//  Maintains horizontal cycle (0..113) and line (0..261) counters for ANTIC/GTIA timing.
//  Gates the CPU phi2 enable for ANTIC DMA cycle stealing, halting only on CPU read cycles.
// PARAMETERS
//  DIV              16   clkin cycles per machine cycle; even, >= 4
//  CYCLES_PER_LINE  114  machine cycles per scan line
//  LINES_PER_FRAME  262  scan lines per frame
// PORTS
//  clkin        in   1   fast clock from clock generator (sole clock)
//  RST          in   1   synchronous, active-high reset
//  halt_req     in   1   ANTIC DMA request; sampled only at phi1 boundary
//  cpu_rw       in   1   CPU R/W of current cycle (1=read); sampled with halt_req
//  phi1_en      out  1   1-clkin strobe, start of machine cycle
//  phi2_en      out  1   1-clkin strobe, start of phi2 half
//  phi2_lvl     out  1   1 during phi2 half (sub_cnt >= DIV/2)
//  cpu_phi2_en  out  1   phi2_en gated by halt state; CPU advances only on this
//  halt_ack     out  1   1 while CPU is halted (state HALTED)
//  cycle_cnt    out  7   horizontal machine-cycle count
//  line_cnt     out  9   scan-line count
//  line_start   out  1   coincident with phi1_en when cycle_cnt becomes 0
//  frame_start  out  1   coincident with line_start when line_cnt becomes 0
// BEHAVIOUR
//  - Internal sub_cnt, clog2(DIV) bits, increments every clkin, wraps DIV-1 -> 0.
//  - All outputs are registered; each is high in the clkin cycle after the edge at which
//    its condition becomes true: phi1_en <-> sub_cnt==0, phi2_en <-> sub_cnt==DIV/2,
//    phi2_lvl <-> sub_cnt>=DIV/2.
//  - RST=1 at an edge: sub_cnt<=DIV-1, cycle_cnt<=CYCLES_PER_LINE-1,
//    line_cnt<=LINES_PER_FRAME-1, state<=RUN, every output 0. Applies mid-halt or
//    mid-cycle alike.
//  - First edge after RST falls: sub_cnt->0; phi1_en, line_start, frame_start all 1;
//    cycle_cnt=0, line_cnt=0.
//  - cycle_cnt advances with each phi1_en, wrapping CYCLES_PER_LINE-1 -> 0.
//  - line_cnt advances only on that wrap, wrapping LINES_PER_FRAME-1 -> 0.
//  - Halt FSM {RUN, PEND, HALTED} evaluates only at the edge ending a phi1_en cycle;
//    halt_req/cpu_rw ignored at all other edges.
//      RUN:    halt_req & cpu_rw -> HALTED; halt_req & ~cpu_rw -> PEND; else RUN
//      PEND:   ~halt_req -> RUN; cpu_rw -> HALTED; else PEND
//      HALTED: ~halt_req -> RUN; else HALTED
//  - cpu_phi2_en = phi2_en when state is RUN or PEND; 0 when HALTED.
//    The transition made at that phi1 edge applies to the same machine cycle's phi2.
//  - halt_ack = (state==HALTED); it changes one clkin after phi1_en deasserts.
//  - PEND covers 6502 write cycles (max 3 consecutive), which cannot be stretched;
//    the CPU keeps running in PEND.
// TESTING (DIV=16, defaults)
//  1 Release RST at edge 0 -> phi1_en high after edges 1,17,33; phi2_en after 9,25;
//    phi2_lvl high after edges 9..16; each strobe exactly 1 clkin wide.
//  2 Free-run 114 machine cycles -> cycle_cnt 113->0 with line_start=1, line_cnt 0->1;
//    after 114*262 cycles -> frame_start=1, line_cnt=0.
//  3 halt_req=1, cpu_rw=1 at a phi1 -> cpu_phi2_en absent that cycle, halt_ack=1;
//    drop halt_req at phi1 three cycles later -> cpu_phi2_en returns that cycle.
//  4 halt_req=1 with cpu_rw=0 for 3 cycles then 1 -> cpu_phi2_en present 3 cycles (PEND),
//    suppressed from the 4th; halt_ack rises at the 4th.
//  5 Toggle halt_req 1->0 between phi1 strobes -> no state change, cpu_phi2_en unaffected.
//  6 Assert RST while HALTED at sub_cnt=5 -> next cycle all outputs 0; after release,
//    sequence identical to test 1.

Source files
------------

// File: rtl/phase_enable_gen.sv
// phase_enable_gen
//   Runs on the fast clock from the clock generator. It produces one-clkin-wide
//   enable strobes for the phi1/phi2 halves of each machine cycle. It keeps the
//   horizontal cycle and scan-line counters used for ANTIC/GTIA timing. It also
//   gates the CPU phi2 enable so that ANTIC DMA can steal cycles.
//
// Ports
//   clkin        in   fast clock, the only clock
//   RST          in   synchronous active-high reset
//   halt_req     in   ANTIC DMA request, sampled only at the end of a phi1_en cycle
//   cpu_rw       in   CPU R/W of the current cycle (1 = read), sampled with halt_req
//   phi1_en      out  1-clkin strobe at the start of a machine cycle
//   phi2_en      out  1-clkin strobe at the start of the phi2 half
//   phi2_lvl     out  high for the whole phi2 half
//   cpu_phi2_en  out  phi2_en, suppressed while the CPU is halted
//   halt_ack     out  high while the CPU is halted
//   cycle_cnt    out  horizontal machine-cycle count, 0..CYCLES_PER_LINE-1
//   line_cnt     out  scan-line count, 0..LINES_PER_FRAME-1
//   line_start   out  coincident with phi1_en when cycle_cnt becomes 0
//   frame_start  out  coincident with line_start when line_cnt becomes 0
module phase_enable_gen #(
  parameter int DIV             = 16,
  parameter int CYCLES_PER_LINE = 114,
  parameter int LINES_PER_FRAME = 262
) (
  input  logic       clkin,
  input  logic       RST,
  input  logic       halt_req,
  input  logic       cpu_rw,
  output logic       phi1_en,
  output logic       phi2_en,
  output logic       phi2_lvl,
  output logic       cpu_phi2_en,
  output logic       halt_ack,
  output logic [6:0] cycle_cnt,
  output logic [8:0] line_cnt,
  output logic       line_start,
  output logic       frame_start
);

  localparam int SW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [SW-1:0] SUB_LAST   = SW'(DIV - 1);
  localparam logic [SW-1:0] SUB_HALF   = SW'(DIV / 2);
  localparam logic [6:0]    CYCLE_LAST = 7'(CYCLES_PER_LINE - 1);
  localparam logic [8:0]    LINE_LAST  = 9'(LINES_PER_FRAME - 1);

  typedef enum logic [1:0] {RUN, PEND, HALTED} state_t;

  state_t          state_reg;
  logic [SW-1:0]   sub_reg;
  logic [6:0]      cycle_reg;
  logic [8:0]      line_reg;
  logic            phi1_reg, phi2_reg, lvl_reg, cpu_phi2_reg, ack_reg;
  logic            line_start_reg, frame_start_reg;

  logic [SW-1:0]   sub_next;
  logic            new_cycle;
  logic [6:0]      cycle_next;
  logic [8:0]      line_next;

  // Every output is registered from the *next* sub_cnt value. A strobe is then
  // high during the clkin cycle after the edge at which its condition holds.
  always_comb begin
    sub_next   = (sub_reg == SUB_LAST) ? '0 : sub_reg + 1'b1;
    new_cycle  = (sub_next == '0);
    cycle_next = cycle_reg;
    line_next  = line_reg;
    if (new_cycle) begin
      cycle_next = (cycle_reg == CYCLE_LAST) ? 7'd0 : cycle_reg + 7'd1;
      if (cycle_reg == CYCLE_LAST)
        line_next = (line_reg == LINE_LAST) ? 9'd0 : line_reg + 9'd1;
    end
  end

  always_ff @(posedge clkin) begin
    if (RST) begin
      // The counters park at their last values. The first edge after release
      // then lands on cycle 0 / line 0 and raises line_start and frame_start.
      sub_reg         <= SUB_LAST;
      cycle_reg       <= CYCLE_LAST;
      line_reg        <= LINE_LAST;
      state_reg       <= RUN;
      phi1_reg        <= 1'b0;
      phi2_reg        <= 1'b0;
      lvl_reg         <= 1'b0;
      cpu_phi2_reg    <= 1'b0;
      ack_reg         <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      sub_reg         <= sub_next;
      cycle_reg       <= cycle_next;
      line_reg        <= line_next;
      phi1_reg        <= new_cycle;
      phi2_reg        <= (sub_next == SUB_HALF);
      lvl_reg         <= (sub_next >= SUB_HALF);
      line_start_reg  <= new_cycle && (cycle_next == 7'd0);
      frame_start_reg <= new_cycle && (cycle_next == 7'd0) && (line_next == 9'd0);

      // The halt FSM only moves on the edge that ends a phi1_en cycle. That edge
      // comes well before the phi2 strobe, so the new state already gates the
      // same machine cycle's cpu_phi2_en.
      if (phi1_reg) begin
        unique case (state_reg)
          RUN:     state_reg <= !halt_req ? RUN  : (cpu_rw ? HALTED : PEND);
          PEND:    state_reg <= !halt_req ? RUN  : (cpu_rw ? HALTED : PEND);
          HALTED:  state_reg <= !halt_req ? RUN  : HALTED;
          default: state_reg <= RUN;
        endcase
      end

      cpu_phi2_reg <= (sub_next == SUB_HALF) && (state_reg != HALTED);
      // halt_ack follows the state one clkin later, so it moves one edge after
      // phi1_en drops.
      ack_reg      <= (state_reg == HALTED);
    end
  end

  assign phi1_en     = phi1_reg;
  assign phi2_en     = phi2_reg;
  assign phi2_lvl    = lvl_reg;
  assign cpu_phi2_en = cpu_phi2_reg;
  assign halt_ack    = ack_reg;
  assign cycle_cnt   = cycle_reg;
  assign line_cnt    = line_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_phase_enable_gen.sv
// Testbench for phase_enable_gen. The reference model counts clkin edges since
// reset was released and derives every output from that count arithmetically.
// The halt state is tracked with the RUN/PEND/HALTED transition rules.
// The frame length is shortened so that a full frame wrap fits a short run.
module tb_phase_enable_gen;

  localparam int DIV = 16;
  localparam int CPL = 114;
  localparam int LPF = 8;

  logic       clk = 1'b0;
  logic       rst, halt_req, cpu_rw;
  logic       phi1_en, phi2_en, phi2_lvl, cpu_phi2_en, halt_ack;
  logic [6:0] cycle_cnt;
  logic [8:0] line_cnt;
  logic       line_start, frame_start;

  int total = 0;
  int bad   = 0;

  phase_enable_gen #(.DIV(DIV), .CYCLES_PER_LINE(CPL), .LINES_PER_FRAME(LPF)) dut (
    .clkin(clk), .RST(rst), .halt_req(halt_req), .cpu_rw(cpu_rw),
    .phi1_en(phi1_en), .phi2_en(phi2_en), .phi2_lvl(phi2_lvl),
    .cpu_phi2_en(cpu_phi2_en), .halt_ack(halt_ack),
    .cycle_cnt(cycle_cnt), .line_cnt(line_cnt),
    .line_start(line_start), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Reference model state. mstate: 0 = RUN, 1 = PEND, 2 = HALTED.
  bit model_ok = 0;
  int k = 0;
  int mstate = 0;
  int exp_sub = 0;
  logic e_phi1, e_phi2, e_lvl, e_cpu2, e_ack, e_ls, e_fs;
  int e_cyc, e_line;

  function automatic int next_state(int s, logic hr, logic rw);
    if (!hr) return 0;
    if (s == 2) return 2;
    return rw ? 2 : 1;
  endfunction

  always @(posedge clk) begin
    int old_state;
    int m;
    if (rst) begin
      model_ok = 1;
      k = 0; mstate = 0; exp_sub = DIV - 1;
      {e_phi1, e_phi2, e_lvl, e_cpu2, e_ack, e_ls, e_fs} = '0;
      e_cyc = CPL - 1; e_line = LPF - 1;
    end else if (model_ok) begin
      old_state = mstate;
      if (e_phi1) mstate = next_state(mstate, halt_req, cpu_rw);
      k++;
      exp_sub = (k - 1) % DIV;
      m       = (k - 1) / DIV;
      e_phi1  = (exp_sub == 0);
      e_phi2  = (exp_sub == DIV / 2);
      e_lvl   = (exp_sub >= DIV / 2);
      e_cyc   = m % CPL;
      e_line  = (m / CPL) % LPF;
      e_ls    = e_phi1 && (e_cyc == 0);
      e_fs    = e_ls && (e_line == 0);
      e_cpu2  = e_phi2 && (mstate != 2);
      e_ack   = (old_state == 2);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, k);
    end
  endtask

  always @(negedge clk) begin
    if (model_ok) begin
      check("phi1_en",     32'(phi1_en),     32'(e_phi1));
      check("phi2_en",     32'(phi2_en),     32'(e_phi2));
      check("phi2_lvl",    32'(phi2_lvl),    32'(e_lvl));
      check("cpu_phi2_en", 32'(cpu_phi2_en), 32'(e_cpu2));
      check("halt_ack",    32'(halt_ack),    32'(e_ack));
      check("cycle_cnt",   32'(cycle_cnt),   32'(e_cyc));
      check("line_cnt",    32'(line_cnt),    32'(e_line));
      check("line_start",  32'(line_start),  32'(e_ls));
      check("frame_start", 32'(frame_start), 32'(e_fs));
    end
  end

  task automatic run_cycles(input int n);
    repeat (n * DIV) @(negedge clk);
  endtask

  int frames_seen = 0;
  always @(negedge clk) if (frame_start === 1'b1) frames_seen++;

  initial begin
    rst = 1'b1; halt_req = 1'b0; cpu_rw = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_cycle", 32'(cycle_cnt), CPL - 1);
    check("reset_line",  32'(line_cnt),  LPF - 1);
    check("reset_phi1",  32'(phi1_en),   0);
    rst = 1'b0;
    @(negedge clk);
    check("first_phi1",  32'(phi1_en),     1);
    check("first_frame", 32'(frame_start), 1);

    // Read-cycle halt: hold for several cycles, then release.
    run_cycles(2);
    halt_req = 1'b1; cpu_rw = 1'b1;
    run_cycles(2);
    check("halt_ack_read", 32'(halt_ack), 1);
    run_cycles(1);
    halt_req = 1'b0;
    run_cycles(2);
    check("halt_ack_release", 32'(halt_ack), 0);

    // Write cycles keep the CPU running in PEND until a read arrives.
    halt_req = 1'b1; cpu_rw = 1'b0;
    run_cycles(3);
    check("pend_no_ack", 32'(halt_ack), 0);
    cpu_rw = 1'b1;
    run_cycles(2);
    check("pend_to_halt", 32'(halt_ack), 1);
    halt_req = 1'b0;
    run_cycles(2);

    // Random inputs that change at arbitrary edges. This run is long enough to
    // pass through a full frame wrap.
    for (int i = 0; i < 1000 * DIV; i++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) halt_req = ~halt_req;
      if ($urandom_range(3) == 0) cpu_rw = 1'($urandom);
    end
    check("frame_wrapped", 32'(frames_seen > 1), 1);

    // Reset while halted at sub_cnt = 5, then replay the startup sequence.
    halt_req = 1'b1; cpu_rw = 1'b1;
    run_cycles(2);
    for (int i = 0; i < 2 * DIV && exp_sub != 5; i++) @(negedge clk);
    check("halted_before_rst", 32'(halt_ack), 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ack",  32'(halt_ack),    0);
    check("rst_phi2", 32'(cpu_phi2_en), 0);
    rst = 1'b0; halt_req = 1'b0;
    run_cycles(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
